jk_counter_reg: RTL

//   Parametrised bank of WIDTH JK flip-flops with a shared clock. Per-bit JK

---
 rtl/jk_counter_reg.sv | 82 ++++++++
 1 files changed

// File: rtl/jk_counter_reg.sv
// jk_counter_reg: bank of WIDTH JK flip-flops sharing one clock, with
// per-bit JK, modulo up/down count and parallel load modes.
// o_wrap is a registered one-cycle pulse that accompanies a wrapping count.
module jk_counter_reg #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qn,
  output logic             o_wrap
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Top count value, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH is representable in the range check.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  mode_e            mode;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  assign mode = mode_e'(i_mode);

  // Next-state selection for the register bank and the wrap flag.
  always_comb begin
    q_next    = o_q;
    wrap_next = 1'b0;
    if (i_en) begin
      case (mode)
        // Per bit: JK=00 hold, 01 clear, 10 set, 11 toggle.
        MODE_JK: q_next = (i_j & ~o_q) | (~i_k & o_q);
        MODE_UP: begin
          if (o_q >= CNT_MAX) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end else begin
            q_next = o_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (o_q == '0) begin
            q_next    = CNT_MAX;
            wrap_next = 1'b1;
          end else if ({1'b0, o_q} >= MOD_EXT) begin
            q_next = CNT_MAX;
          end else begin
            q_next = o_q - WIDTH'(1);
          end
        end
        MODE_LOAD: q_next = i_d;
      endcase
    end
  end

  // State register with synchronous reset taking priority over enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q    <= '0;
      o_wrap <= 1'b0;
    end else begin
      o_q    <= q_next;
      o_wrap <= wrap_next;
    end
  end

  assign o_qn = ~o_q;

endmodule
